bht_predictor: RTL and testbench
================================

Name: bht_predictor

Overview:
- Direct-mapped branch history table of saturating counters for the fetch stage of the RISC-V core.
- Fetch presents a PC and receives a registered taken/not-taken prediction one cycle later.
- Execute writes back resolved branch outcomes, which increment or decrement the indexed counter with saturation at both ends.
- Sits between PC generation (upstream) and the next-PC mux (downstream).

Parameters:
- INDEX_BITS, 4, log2 of table depth; table has 2^INDEX_BITS entries.
- CTR_WIDTH, 2, width of each saturating counter.
- CTR_INIT, 1, reset value of every counter (weakly not-taken for CTR_WIDTH=2); must be < 2^CTR_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low; asserted when 0.
- lookup_valid  input  1  fetch requests a prediction this cycle.
- lookup_pc  input  32  PC of the instruction being fetched.
- stall  input  1  hold prediction outputs; lookup ignored while high.
- flush  input  1  squash the in-flight prediction.
- pred_valid  output  1  pred_taken/pred_ctr valid this cycle.
- pred_taken  output  1  predicted direction (counter MSB).
- pred_ctr  output  CTR_WIDTH  counter value the prediction was based on.
- update_valid  input  1  resolved branch outcome present.
- update_pc  input  32  PC of the resolved branch.
- update_taken  input  1  actual branch outcome.

Behaviour:
- Index: idx = pc[INDEX_BITS+1:2]. PC bits [1:0] are ignored, and tags are not stored (aliasing is allowed).
- Reset (reset==0, asynchronous):
  - Every table entry becomes CTR_INIT.
  - pred_valid=0, pred_taken=0, pred_ctr=0.
  - Deassertion is sampled synchronously; the first lookup is accepted on the first rising edge with reset==1.
- Lookup latency: 1 cycle.
  - On an edge with lookup_valid=1, stall=0, flush=0: pred_valid<=1, pred_ctr<=table[idx], pred_taken<=table[idx][CTR_WIDTH-1].
  - On an edge with lookup_valid=0, stall=0, flush=0: pred_valid<=0. pred_taken and pred_ctr hold their previous values.
- Stall: while stall=1 and flush=0, pred_valid, pred_taken and pred_ctr hold their values and lookup_pc is ignored.
- Flush: on an edge with flush=1, pred_valid<=0 regardless of stall or lookup_valid. Flush does not modify the table.
- Update (single-cycle read-modify-write on the edge where update_valid=1):
  - update_taken=1 and ctr < 2^CTR_WIDTH-1: ctr+1. If ctr == 2^CTR_WIDTH-1, hold (saturate high).
  - update_taken=0 and ctr > 0: ctr-1. If ctr == 0, hold (saturate low).
  - The arithmetic never wraps; compare before incrementing or decrementing.
  - Updates proceed during stall and flush.
- Simultaneous lookup and update:
  - Same index: the prediction uses the post-update counter value (write-first bypass). The stored table value and pred_ctr agree at the next cycle.
  - Different index: the two operations are independent.
- Reset mid-operation: the table and outputs reinitialise immediately (no clock required). An update in flight is discarded.
- A single table write occurs per cycle, so there are no write conflicts.
- Implementation: flop array; no SRAM macro.

Test Plan:
- Reset then lookup: release reset, lookup_pc=0x0000_0040 (idx 0) -> next cycle pred_valid=1, pred_ctr=1, pred_taken=0.
- Saturate high: 4 updates taken on pc=0x44 (idx 1), then lookup -> pred_ctr=3, pred_taken=1; a 5th taken update still gives 3.
- Saturate low: 3 not-taken updates on pc=0x48 (idx 2), then lookup -> pred_ctr=0, pred_taken=0; no wrap to 3.
- Bypass: entry idx 3 = 1; same cycle: lookup pc=0x4C and update pc=0x4C taken -> next cycle pred_ctr=2, pred_taken=1.
- Aliasing and independence: update pc=0x80 (idx 0, aliases 0x40) taken twice -> lookup pc=0x40 gives pred_ctr=3. Simultaneous update idx 5 and lookup idx 6 -> prediction reflects idx 6 unchanged (pred_ctr=1).
- Stall, flush and reset mid-run:
  - Stall: holding stall=1 for 3 cycles with varying lookup_pc keeps pred_* constant.
  - Flush: flush=1 with lookup_valid=1 gives pred_valid=0 next cycle.
  - Reset: asserting reset between clock edges immediately gives pred_valid=0, and all entries read 1 afterwards.

Source files
------------

// File: rtl/bht_predictor_if.sv
// Fetch/execute-facing signal bundle of the branch history table predictor.
// The master side is the core (fetch and execute), the slave side is the predictor.
interface bht_predictor_if #(
    parameter int CTR_WIDTH = 2
);
    logic                 lookup_valid;
    logic [31:0]          lookup_pc;
    logic                 stall;
    logic                 flush;
    logic                 pred_valid;
    logic                 pred_taken;
    logic [CTR_WIDTH-1:0] pred_ctr;
    logic                 update_valid;
    logic [31:0]          update_pc;
    logic                 update_taken;

    modport master (
        output lookup_valid, lookup_pc, stall, flush,
        output update_valid, update_pc, update_taken,
        input  pred_valid, pred_taken, pred_ctr
    );

    modport slave (
        input  lookup_valid, lookup_pc, stall, flush,
        input  update_valid, update_pc, update_taken,
        output pred_valid, pred_taken, pred_ctr
    );
endinterface

// File: rtl/bht_predictor.sv
// Direct-mapped, untagged table of saturating counters giving a registered
// taken/not-taken prediction one cycle after a fetch lookup.
module bht_predictor #(
    parameter int INDEX_BITS = 4,
    parameter int CTR_WIDTH  = 2,
    parameter int CTR_INIT   = 1
) (
    input logic          clk,
    input logic          reset,
    bht_predictor_if.slave bus
);
    localparam int DEPTH = 1 << INDEX_BITS;

    typedef logic [CTR_WIDTH-1:0]  ctr_t;
    typedef logic [INDEX_BITS-1:0] idx_t;

    localparam ctr_t CTR_RESET = ctr_t'(CTR_INIT);
    localparam ctr_t CTR_MAX   = '1;
    localparam ctr_t CTR_MIN   = '0;

    ctr_t ctr_table [DEPTH];

    idx_t lookup_idx;
    idx_t update_idx;
    ctr_t update_cur;
    ctr_t update_next;
    ctr_t lookup_ctr;
    logic unused_pc_bits;

    assign lookup_idx = bus.lookup_pc[INDEX_BITS+1:2];
    assign update_idx = bus.update_pc[INDEX_BITS+1:2];

    // Tags are not stored, so the low and high PC bits play no part.
    assign unused_pc_bits = ^{bus.lookup_pc[31:INDEX_BITS+2], bus.lookup_pc[1:0],
                              bus.update_pc[31:INDEX_BITS+2], bus.update_pc[1:0]};

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        update_cur  = ctr_table[update_idx];
        update_next = update_cur;
        if (bus.update_taken) begin
            if (update_cur != CTR_MAX) update_next = update_cur + ctr_t'(1);
        end else begin
            if (update_cur != CTR_MIN) update_next = update_cur - ctr_t'(1);
        end
    end

    // Write-first bypass: a same-index update this cycle is visible to the lookup.
    always_comb begin
        lookup_ctr = ctr_table[lookup_idx];
        if (bus.update_valid && (update_idx == lookup_idx)) lookup_ctr = update_next;
    end

    // NOTE: the counter array is a flop array that must come out of reset weakly
    // not-taken, so it is reset like any other state rather than left uninitialised.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) ctr_table[i] <= CTR_RESET;
        end else if (bus.update_valid) begin
            ctr_table[update_idx] <= update_next;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.pred_valid <= 1'b0;
            bus.pred_taken <= 1'b0;
            bus.pred_ctr   <= '0;
        end else if (bus.flush) begin
            bus.pred_valid <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.lookup_valid) begin
                bus.pred_valid <= 1'b1;
                bus.pred_ctr   <= lookup_ctr;
                bus.pred_taken <= lookup_ctr[CTR_WIDTH-1];
            end else begin
                bus.pred_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor: directed steps from the test plan followed by
// randomized traffic, all compared against an integer-arithmetic reference model.
module tb_bht_predictor;
    localparam int INDEX_BITS = 4;
    localparam int CTR_WIDTH  = 2;
    localparam int CTR_INIT   = 1;
    localparam int DEPTH      = 1 << INDEX_BITS;
    localparam int CMAX       = (1 << CTR_WIDTH) - 1;

    logic clk;
    logic reset;

    bht_predictor_if #(.CTR_WIDTH(CTR_WIDTH)) bus ();

    bht_predictor #(
        .INDEX_BITS(INDEX_BITS),
        .CTR_WIDTH (CTR_WIDTH),
        .CTR_INIT  (CTR_INIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared = 0;
    int n_mismatch = 0;

    // Reference model: plain integer counters and expected outputs.
    int mtab [DEPTH];
    int exp_valid;
    int exp_taken;
    int exp_ctr;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mtab[i] = CTR_INIT;
        exp_valid = 0;
        exp_taken = 0;
        exp_ctr   = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatch++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One clock: apply inputs, advance the model, then compare just after the edge.
    task automatic drive(input string tag, input bit lv, input logic [31:0] lpc, input bit st,
                         input bit fl, input bit uv, input logic [31:0] upc, input bit ut);
        int u;
        bus.lookup_valid = lv;
        bus.lookup_pc    = lpc;
        bus.stall        = st;
        bus.flush        = fl;
        bus.update_valid = uv;
        bus.update_pc    = upc;
        bus.update_taken = ut;
        if (uv) begin
            u = idx_of(upc);
            mtab[u] = ut ? ((mtab[u] + 1 > CMAX) ? CMAX : mtab[u] + 1)
                         : ((mtab[u] - 1 < 0) ? 0 : mtab[u] - 1);
        end
        if (fl) begin
            exp_valid = 0;
        end else if (!st) begin
            if (lv) begin
                exp_valid = 1;
                exp_ctr   = mtab[idx_of(lpc)];
                exp_taken = (exp_ctr >= (CMAX + 1) / 2) ? 1 : 0;
            end else begin
                exp_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 32'(bus.pred_valid), 32'(exp_valid));
        check({tag, "_taken"}, 32'(bus.pred_taken), 32'(exp_taken));
        check({tag, "_ctr"},   32'(bus.pred_ctr),   32'(exp_ctr));
    endtask

    task automatic idle(input string tag);
        drive(tag, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc);
        drive(tag, 1'b1, pc, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic update(input string tag, input logic [31:0] pc, input bit taken);
        drive(tag, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, pc, taken);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [CTR_WIDTH-1:0] held_ctr;
        logic                 held_taken;
        logic                 held_valid;
        bit lv, st, fl, uv, ut;
        logic [31:0] lpc, upc;

        reset = 1'b0;
        bus.lookup_valid = 1'b0;
        bus.lookup_pc    = '0;
        bus.stall        = 1'b0;
        bus.flush        = 1'b0;
        bus.update_valid = 1'b0;
        bus.update_pc    = '0;
        bus.update_taken = 1'b0;
        model_reset();

        // Reset state
        #3;
        check("reset_valid", 32'(bus.pred_valid), 32'd0);
        check("reset_taken", 32'(bus.pred_taken), 32'd0);
        check("reset_ctr",   32'(bus.pred_ctr),   32'd0);
        #4 reset = 1'b1;

        // First lookup after reset release
        lookup("first_lookup", 32'h0000_0040);
        check("first_lookup_ctr_const", 32'(bus.pred_ctr), 32'd1);

        // Saturate high on idx 1
        for (int i = 0; i < 4; i++) update("sat_hi_upd", 32'h44, 1'b1);
        lookup("sat_hi_lookup", 32'h44);
        check("sat_hi_ctr_const", 32'(bus.pred_ctr), 32'd3);
        check("sat_hi_taken_const", 32'(bus.pred_taken), 32'd1);
        update("sat_hi_upd5", 32'h44, 1'b1);
        lookup("sat_hi_lookup5", 32'h44);
        check("sat_hi_ctr5_const", 32'(bus.pred_ctr), 32'd3);

        // Saturate low on idx 2
        for (int i = 0; i < 3; i++) update("sat_lo_upd", 32'h48, 1'b0);
        lookup("sat_lo_lookup", 32'h48);
        check("sat_lo_ctr_const", 32'(bus.pred_ctr), 32'd0);
        check("sat_lo_taken_const", 32'(bus.pred_taken), 32'd0);

        // Same-index lookup and update: write-first bypass
        drive("bypass", 1'b1, 32'h4C, 1'b0, 1'b0, 1'b1, 32'h4C, 1'b1);
        check("bypass_ctr_const", 32'(bus.pred_ctr), 32'd2);
        check("bypass_taken_const", 32'(bus.pred_taken), 32'd1);
        lookup("bypass_stored", 32'h4C);
        check("bypass_stored_const", 32'(bus.pred_ctr), 32'd2);

        // Aliasing: 0x80 and 0x40 share idx 0
        update("alias_upd", 32'h80, 1'b1);
        update("alias_upd", 32'h80, 1'b1);
        lookup("alias_lookup", 32'h40);
        check("alias_ctr_const", 32'(bus.pred_ctr), 32'd3);

        // Independence: update idx 5 while looking up idx 6
        drive("indep", 1'b1, 32'h58, 1'b0, 1'b0, 1'b1, 32'h54, 1'b1);
        check("indep_ctr_const", 32'(bus.pred_ctr), 32'd1);

        // Stall holds outputs for 3 cycles despite changing lookup_pc
        lookup("pre_stall", 32'h44);
        held_valid = bus.pred_valid;
        held_taken = bus.pred_taken;
        held_ctr   = bus.pred_ctr;
        for (int i = 0; i < 3; i++) begin
            drive("stall", 1'b1, 32'h48 + 32'(i * 4), 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            check("stall_hold_valid", 32'(bus.pred_valid), 32'(held_valid));
            check("stall_hold_taken", 32'(bus.pred_taken), 32'(held_taken));
            check("stall_hold_ctr",   32'(bus.pred_ctr),   32'(held_ctr));
        end

        // Flush beats lookup_valid and stall
        drive("flush", 1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("flush_valid_const", 32'(bus.pred_valid), 32'd0);
        lookup("post_flush", 32'h44);
        drive("flush_stall", 1'b1, 32'h48, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        check("flush_stall_valid_const", 32'(bus.pred_valid), 32'd0);

        // Reset between edges with an update in flight
        lookup("pre_reset", 32'h44);
        bus.update_valid = 1'b1;
        bus.update_pc    = 32'h5C;
        bus.update_taken = 1'b1;
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("midreset_valid", 32'(bus.pred_valid), 32'd0);
        check("midreset_ctr",   32'(bus.pred_ctr),   32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            lookup("post_reset_scan", 32'(i * 4) + 32'h1000);
            check("post_reset_entry", 32'(bus.pred_ctr), 32'd1);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            lv  = ($urandom_range(99) < 70);
            st  = ($urandom_range(99) < 15);
            fl  = ($urandom_range(99) < 8);
            uv  = ($urandom_range(99) < 60);
            ut  = ($urandom_range(99) < 55);
            lpc = $urandom;
            upc = ($urandom_range(99) < 30) ? (lpc ^ ($urandom & 32'hFFFF_FFC3)) : $urandom;
            drive("rand", lv, lpc, st, fl, uv, upc, ut);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end
endmodule
